lsu_agu: RTL and testbench

Effective-address generation stage of the load/store unit. It sits between instruction decode and the data-memory request port. It accepts a base register value, a 12-bit signed offset, a store flag, an access size and store data. It computes the 32-bit effective address as two sequential passes through one shared 16-bit Brent-Kung adder (`bkadder`), low half first with the carry registered into the high half. It then emits a memory request with byte enables, lane-aligned store data and a misalignment flag over a valid/ready handshake.

---
 rtl/lsu_agu_if.sv | 32 +++
 rtl/lsu_agu.sv | 188 ++++++++++++++++++
 tb/tb_lsu_agu.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/lsu_agu_if.sv
// Decode-side request and memory-side response bundle of the LSU address stage.
// master = upstream/downstream environment, slave = the AGU itself.
interface lsu_agu_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_base;
    logic [11:0] in_imm;
    logic        in_is_store;
    logic [1:0]  in_size;
    logic [31:0] in_wdata;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_addr;
    logic        out_is_store;
    logic [1:0]  out_size;
    logic [31:0] out_wdata;
    logic [3:0]  out_be;
    logic        out_misaligned;

    modport master (
        output in_valid, in_base, in_imm, in_is_store, in_size, in_wdata, out_ready,
        input  in_ready, out_valid, out_addr, out_is_store, out_size, out_wdata,
               out_be, out_misaligned
    );

    modport slave (
        input  in_valid, in_base, in_imm, in_is_store, in_size, in_wdata, out_ready,
        output in_ready, out_valid, out_addr, out_is_store, out_size, out_wdata,
               out_be, out_misaligned
    );
endinterface

// File: rtl/lsu_agu.sv
// LSU effective-address stage: base + sext(imm) in two 16-bit passes through one
// shared Brent-Kung adder, then byte enables / lane-aligned store data.

module bkadder (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);
    always_comb begin
        logic [15:0] g;
        logic [15:0] p;
        g    = a & b;
        p    = a ^ b;
        // Fold carry-in into bit 0 so the prefix tree yields carries directly.
        g[0] = g[0] | (p[0] & cin);
        for (int s = 1; s < 16; s = s * 2)
            for (int i = 2 * s - 1; i < 16; i = i + 2 * s) begin
                g[i] = g[i] | (p[i] & g[i - s]);
                p[i] = p[i] & p[i - s];
            end
        for (int s = 4; s >= 1; s = s / 2)
            for (int i = 3 * s - 1; i < 16; i = i + 2 * s) begin
                g[i] = g[i] | (p[i] & g[i - s]);
                p[i] = p[i] & p[i - s];
            end
        sum  = a ^ b ^ {g[14:0], cin};
        cout = g[15];
    end
endmodule

module lsu_agu_lane #(
    parameter int LANE = 0
) (
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        misal,
    input  logic        is_store,
    input  logic [31:0] wdata,
    output logic        be,
    output logic [7:0]  wbyte
);
    localparam logic [1:0] LID = 2'(LANE);
    logic [1:0] idx;

    assign idx = LID - off;

    always_comb begin
        case (size)
            2'b00:   be = (off == LID);
            2'b01:   be = (off[1] == LID[1]);
            2'b10:   be = 1'b1;
            default: be = 1'b0;
        endcase
        if (misal) be = 1'b0;
    end

    // Lane picks source byte (LANE - off); lanes below the offset are shifted-in zeros.
    assign wbyte = (is_store && !misal && off <= LID) ? wdata[{idx, 3'b000} +: 8] : 8'h00;
endmodule

module lsu_agu (
    input  logic     clk,
    input  logic     rst_n,
    lsu_agu_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_OUT} state_t;

    typedef struct packed {
        logic [31:0] base;
        logic [31:0] imm;
        logic        is_store;
        logic [1:0]  size;
        logic [31:0] wdata;
    } req_t;

    state_t            state_q, state_d;
    req_t              req_q;
    logic [31:0]       addr_q;
    logic              carry_q;
    logic [3:0]        be_q;
    logic [31:0]       wd_q;
    logic              mis_q, st_q;
    logic [1:0]        sz_q;

    logic              acc;
    logic [15:0]       add_a, add_b, add_sum;
    logic              add_cin, add_cout;
    logic              misal;
    logic [3:0]        be_d;
    logic [3:0][7:0]   wd_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.in_valid) state_d = S_LO;
            S_LO:   state_d = S_HI;
            S_HI:   state_d = S_OUT;
            S_OUT:  if (bus.out_ready) state_d = bus.in_valid ? S_LO : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = rst_n & ((state_q == S_IDLE) | ((state_q == S_OUT) & bus.out_ready));
        bus.out_valid = (state_q == S_OUT);
        add_a         = req_q.base[15:0];
        add_b         = req_q.imm[15:0];
        add_cin       = 1'b0;
        if (state_q == S_HI) begin
            add_a   = req_q.base[31:16];
            add_b   = req_q.imm[31:16];
            add_cin = carry_q;
        end
    end

    assign acc = bus.in_valid & bus.in_ready;

    bkadder u_add (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Alignment only depends on the low address bits, already registered after LO.
    assign misal = (req_q.size == 2'b11) |
                   ((req_q.size == 2'b01) & addr_q[0]) |
                   ((req_q.size == 2'b10) & (addr_q[1:0] != 2'b00));

    for (genvar l = 0; l < 4; l++) begin : g_lane
        lsu_agu_lane #(.LANE(l)) u_lane (
            .off      (addr_q[1:0]),
            .size     (req_q.size),
            .misal    (misal),
            .is_store (req_q.is_store),
            .wdata    (req_q.wdata),
            .be       (be_d[l]),
            .wbyte    (wd_d[l])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q   <= '0;
            addr_q  <= '0;
            carry_q <= 1'b0;
            be_q    <= '0;
            wd_q    <= '0;
            mis_q   <= 1'b0;
            st_q    <= 1'b0;
            sz_q    <= '0;
        end else begin
            if (acc)
                req_q <= '{base:     bus.in_base,
                           imm:      {{20{bus.in_imm[11]}}, bus.in_imm},
                           is_store: bus.in_is_store,
                           size:     bus.in_size,
                           wdata:    bus.in_wdata};
            if (state_q == S_LO) begin
                addr_q[15:0] <= add_sum;
                carry_q      <= add_cout;
            end
            if (state_q == S_HI) begin
                addr_q[31:16] <= add_sum;
                be_q          <= be_d;
                wd_q          <= wd_d;
                mis_q         <= misal;
                st_q          <= req_q.is_store;
                sz_q          <= req_q.size;
            end
        end
    end

    assign bus.out_addr       = addr_q;
    assign bus.out_be         = be_q;
    assign bus.out_wdata      = wd_q;
    assign bus.out_misaligned = mis_q;
    assign bus.out_is_store   = st_q;
    assign bus.out_size       = sz_q;
endmodule

// File: tb/tb_lsu_agu.sv
// Directed bench for lsu_agu: hand-computed addresses, enables, store lanes,
// latency, backpressure and mid-operation reset.
module tb_lsu_agu;
    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;

    lsu_agu_if bus ();

    lsu_agu dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] b, input logic [11:0] im, input logic st,
                         input logic [1:0] sz, input logic [31:0] wd);
        bus.in_base     = b;
        bus.in_imm      = im;
        bus.in_is_store = st;
        bus.in_size     = sz;
        bus.in_wdata    = wd;
    endtask

    // Present a request, wait (bounded) for in_ready, accept it, then scramble the inputs.
    task automatic send(input logic [31:0] b, input logic [11:0] im, input logic st,
                        input logic [1:0] sz, input logic [31:0] wd);
        int w;
        drive(b, im, st, sz, wd);
        bus.in_valid = 1'b1;
        w = 0;
        while (!bus.in_ready && w < 20) begin
            step();
            w++;
        end
        chk("accept_rdy", bus.in_ready, 1);
        step();
        bus.in_valid = 1'b0;
        drive(32'hDEAD_BEEF, 12'h5A5, ~st, ~sz, 32'hFFFF_FFFF);
    endtask

    // Called right after the accept edge with out_ready high.
    task automatic expect_out(input string tag, input logic [31:0] a, input logic [3:0] be,
                              input logic [31:0] wd, input logic mis, input logic st,
                              input logic [1:0] sz);
        chk({tag, "_vld_lo"}, bus.out_valid, 0);
        step();
        chk({tag, "_vld_hi"}, bus.out_valid, 0);
        step();
        chk({tag, "_vld"},   bus.out_valid, 1);
        chk({tag, "_addr"},  bus.out_addr, a);
        chk({tag, "_be"},    bus.out_be, be);
        chk({tag, "_wdata"}, bus.out_wdata, wd);
        chk({tag, "_mis"},   bus.out_misaligned, mis);
        chk({tag, "_st"},    bus.out_is_store, st);
        chk({tag, "_sz"},    bus.out_size, sz);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drive(32'h0, 12'h0, 1'b0, 2'b00, 32'h0);
        repeat (2) step();

        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_addr", bus.out_addr, 0);
        chk("rst_be", bus.out_be, 0);
        chk("rst_wdata", bus.out_wdata, 0);
        chk("rst_mis", bus.out_misaligned, 0);
        chk("rst_st", bus.out_is_store, 0);
        chk("rst_sz", bus.out_size, 0);
        rst_n = 1'b1;
        #1;
        chk("idle_in_ready", bus.in_ready, 1);

        send(32'h0000_1000, 12'h004, 1'b0, 2'b10, 32'h1111_2222);
        expect_out("wload", 32'h0000_1004, 4'b1111, 32'h0, 1'b0, 1'b0, 2'b10);

        send(32'h0000_FFFF, 12'h001, 1'b1, 2'b00, 32'h0000_00AB);
        expect_out("carry", 32'h0001_0000, 4'b0001, 32'h0000_00AB, 1'b0, 1'b1, 2'b00);

        send(32'h0000_0000, 12'hFFF, 1'b0, 2'b00, 32'h0);
        expect_out("neg1", 32'hFFFF_FFFF, 4'b1000, 32'h0, 1'b0, 1'b0, 2'b00);

        send(32'hFFFF_FFFF, 12'h001, 1'b0, 2'b00, 32'h0);
        expect_out("wrap", 32'h0000_0000, 4'b0001, 32'h0, 1'b0, 1'b0, 2'b00);

        send(32'h0000_2000, 12'h002, 1'b1, 2'b01, 32'h0000_1234);
        expect_out("half", 32'h0000_2002, 4'b1100, 32'h1234_0000, 1'b0, 1'b1, 2'b01);

        send(32'h0000_2001, 12'h000, 1'b1, 2'b01, 32'h0000_1234);
        expect_out("half_mis", 32'h0000_2001, 4'b0000, 32'h0, 1'b1, 1'b1, 2'b01);

        send(32'h0000_3000, 12'h000, 1'b1, 2'b11, 32'hDEAD_BEEF);
        expect_out("rsvd", 32'h0000_3000, 4'b0000, 32'h0, 1'b1, 1'b1, 2'b11);

        send(32'h1234_0004, 12'hFF8, 1'b1, 2'b10, 32'hCAFE_F00D);
        expect_out("borrow", 32'h1233_FFFC, 4'b1111, 32'hCAFE_F00D, 1'b0, 1'b1, 2'b10);

        send(32'h0000_0100, 12'h001, 1'b1, 2'b00, 32'h1122_3344);
        expect_out("byte1", 32'h0000_0101, 4'b0010, 32'h2233_4400, 1'b0, 1'b1, 2'b00);

        // Backpressure: hold OUT for 5 cycles with a new request waiting.
        bus.out_ready = 1'b0;
        send(32'h0000_5000, 12'h010, 1'b1, 2'b10, 32'h55AA_55AA);
        step();
        step();
        drive(32'h0000_6000, 12'h006, 1'b0, 2'b01, 32'h0);
        bus.in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("bp_vld", bus.out_valid, 1);
            chk("bp_in_ready", bus.in_ready, 0);
            chk("bp_addr", bus.out_addr, 32'h0000_5010);
            chk("bp_wdata", bus.out_wdata, 32'h55AA_55AA);
            chk("bp_be", bus.out_be, 4'b1111);
            step();
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_rdy", bus.in_ready, 1);
        step();
        bus.in_valid = 1'b0;
        drive(32'hDEAD_BEEF, 12'h5A5, 1'b1, 2'b11, 32'hFFFF_FFFF);
        expect_out("b2b", 32'h0000_6006, 4'b1100, 32'h0, 1'b0, 1'b0, 2'b01);

        // Reset while the transaction sits in HI.
        send(32'h0000_7000, 12'h234, 1'b1, 2'b10, 32'hA5A5_A5A5);
        step();
        rst_n = 1'b0;
        #1;
        chk("mrst_vld", bus.out_valid, 0);
        chk("mrst_in_ready", bus.in_ready, 0);
        chk("mrst_addr", bus.out_addr, 0);
        chk("mrst_wdata", bus.out_wdata, 0);
        chk("mrst_be", bus.out_be, 0);
        step();
        step();
        chk("mrst_vld2", bus.out_valid, 0);
        rst_n = 1'b1;
        #1;
        chk("mrst_idle_rdy", bus.in_ready, 1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("mrst_no_out", bus.out_valid, 0);
        end

        send(32'h0000_0010, 12'h000, 1'b0, 2'b10, 32'h0);
        expect_out("post_rst", 32'h0000_0010, 4'b1111, 32'h0, 1'b0, 1'b0, 2'b10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
